// File: rtl/data_memory_unit.sv
// Byte-addressable RV32I data memory: synchronous byte-enabled stores, combinational
// sign/zero-extending loads, sticky first-fault capture and saturating access counters.
module data_memory_unit #(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] DataWr,
  input  logic        DMWr,
  input  logic        DMRd,
  input  logic [2:0]  DMCtrl,
  output logic [31:0] DataRd,
  output logic        Fault,
  output logic        FaultCause,
  output logic [31:0] FaultAddr,
  output logic [15:0] LoadCount,
  output logic [15:0] StoreCount
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    ext_byte = {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    ext_half = {{16{sgn & h[15]}}, h};
  endfunction

  logic [7:0]           mem_q [DEPTH];
  logic [7:0]           mem_d [DEPTH];
  logic                 fault_q, fault_d;
  logic                 cause_q, cause_d;
  logic [31:0]          faddr_q, faddr_d;
  logic [15:0]          lcnt_q, lcnt_d;
  logic [15:0]          scnt_q, scnt_d;

  logic [ADDR_BITS-1:0] a0_s, a1_s, a2_s, a3_s;
  logic                 is_st_s, is_ld_s;
  logic                 ill_ld_s, ill_st_s, ill_s, mis_s;
  logic                 acc_fault_s, st_ok_s, ld_ok_s;
  logic [31:0]          rd_data_s;

  assign a0_s    = Address[ADDR_BITS-1:0];
  assign a1_s    = a0_s + ADDR_BITS'(1);
  assign a2_s    = a0_s + ADDR_BITS'(2);
  assign a3_s    = a0_s + ADDR_BITS'(3);
  assign is_st_s = DMWr;
  assign is_ld_s = DMRd & ~DMWr;

  // Access decode: legality per direction, alignment by access size.
  always_comb begin
    ill_ld_s = 1'b1;
    ill_st_s = 1'b1;
    mis_s    = 1'b0;
    case (DMCtrl)
      3'b000, 3'b001, 3'b010: begin
        ill_ld_s = 1'b0;
        ill_st_s = 1'b0;
      end
      3'b100, 3'b101: ill_ld_s = 1'b0;
      default: begin
        ill_ld_s = 1'b1;
        ill_st_s = 1'b1;
      end
    endcase
    case (DMCtrl[1:0])
      2'b01:   mis_s = a0_s[0];
      2'b10:   mis_s = |a0_s[1:0];
      default: mis_s = 1'b0;
    endcase
    if (is_st_s) begin
      ill_s = ill_st_s;
    end else begin
      ill_s = ill_ld_s;
    end
    acc_fault_s = (is_st_s | is_ld_s) & (ill_s | mis_s);
    st_ok_s     = is_st_s & ~ill_s & ~mis_s;
    ld_ok_s     = is_ld_s & ~ill_s & ~mis_s;
  end

  // Load path: reads current contents, so a same-cycle store is not yet visible.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    if (ld_ok_s) begin
      case (DMCtrl)
        3'b000:  rd_data_s = ext_byte(mem_q[a0_s], 1'b1);
        3'b001:  rd_data_s = ext_half({mem_q[a1_s], mem_q[a0_s]}, 1'b1);
        3'b010:  rd_data_s = {mem_q[a3_s], mem_q[a2_s], mem_q[a1_s], mem_q[a0_s]};
        3'b100:  rd_data_s = ext_byte(mem_q[a0_s], 1'b0);
        3'b101:  rd_data_s = ext_half({mem_q[a1_s], mem_q[a0_s]}, 1'b0);
        default: rd_data_s = 32'h0000_0000;
      endcase
    end else begin
      rd_data_s = 32'h0000_0000;
    end
  end

  // Store path: little-endian byte lanes, suppressed entirely on a fault.
  always_comb begin
    mem_d = mem_q;
    if (st_ok_s) begin
      case (DMCtrl)
        3'b000: mem_d[a0_s] = DataWr[7:0];
        3'b001: begin
          mem_d[a0_s] = DataWr[7:0];
          mem_d[a1_s] = DataWr[15:8];
        end
        3'b010: begin
          mem_d[a0_s] = DataWr[7:0];
          mem_d[a1_s] = DataWr[15:8];
          mem_d[a2_s] = DataWr[23:16];
          mem_d[a3_s] = DataWr[31:24];
        end
        default: mem_d = mem_q;
      endcase
    end else begin
      mem_d = mem_q;
    end
  end

  // First-fault capture and saturating counters.
  always_comb begin
    fault_d = fault_q;
    cause_d = cause_q;
    faddr_d = faddr_q;
    lcnt_d  = lcnt_q;
    scnt_d  = scnt_q;
    if (acc_fault_s && !fault_q) begin
      fault_d = 1'b1;
      cause_d = ill_s;
      faddr_d = Address;
    end else begin
      fault_d = fault_q;
    end
    if (ld_ok_s && (lcnt_q != 16'hFFFF)) begin
      lcnt_d = lcnt_q + 16'd1;
    end else begin
      lcnt_d = lcnt_q;
    end
    if (st_ok_s && (scnt_q != 16'hFFFF)) begin
      scnt_d = scnt_q + 16'd1;
    end else begin
      scnt_d = scnt_q;
    end
  end

  // State registers; reset clears the whole array so a pending store is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      fault_q <= 1'b0;
      cause_q <= 1'b0;
      faddr_q <= 32'h0000_0000;
      lcnt_q  <= 16'h0000;
      scnt_q  <= 16'h0000;
    end else begin
      mem_q   <= mem_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      faddr_q <= faddr_d;
      lcnt_q  <= lcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign DataRd     = rd_data_s;
  assign Fault      = fault_q;
  assign FaultCause = cause_q;
  assign FaultAddr  = faddr_q;
  assign LoadCount  = lcnt_q;
  assign StoreCount = scnt_q;

endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
- Byte-addressable data memory for the single-cycle RV32I core: the consumer of the store-enable and width/sign controls the control unit drives (DMWr, DMCtrl = Funct3).
- Stores are synchronous with byte enables. Loads are combinational, with sign/zero extension.
- Adds a sticky misalignment/illegal-access fault capture and saturating load/store counters for debug and verification.
- Sits between the ALU result (address), the rs2 read port (store data) and the writeback mux.

Parameters:
- DEPTH, 256, memory size in bytes; power of two, minimum 4.
- ADDR_BITS, 8, log2(DEPTH); the address index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- Address  in  32  byte address from the ALU; only Address[ADDR_BITS-1:0] indexes the array (wrap modulo DEPTH)
- DataWr  in  32  store data (rs2)
- DMWr  in  1  store request
- DMRd  in  1  load request
- DMCtrl  in  3  access type, Funct3 encoding
- DataRd  out  32  extended load data, combinational
- Fault  out  1  sticky fault flag
- FaultCause  out  1  0 = misaligned, 1 = illegal DMCtrl; valid while Fault = 1
- FaultAddr  out  32  full Address of the first faulting access
- LoadCount  out  16  accepted loads, saturating
- StoreCount  out  16  accepted stores, saturating

Behaviour:
- Reset (async, rst = 1):
  - All DEPTH bytes cleared to 0.
  - Fault, FaultCause, FaultAddr, LoadCount, StoreCount cleared to 0.
  - DataRd therefore reads 0 for any legal aligned load.
  - Reset asserted mid-cycle aborts the pending store; nothing is written at the following edge.
- DMCtrl encoding:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Illegal for loads: 011, 110, 111. Illegal for stores: 011 through 111.
- Byte order:
  - Little-endian; byte k of the word lives at index (A + k), with A = Address[ADDR_BITS-1:0].
- Alignment:
  - Halfword requires A[0] = 0; word requires A[1:0] = 00; bytes are always aligned.
  - Halfword/word never wrap past DEPTH-1 because alignment is enforced.
- Load path (combinational, zero latency):
  - Applies when DMRd = 1 and DMWr = 0.
  - Legal access: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW returns 4 bytes.
  - Faulting access: DataRd = 0.
  - DMRd = 0: DataRd = 0.
- Store path:
  - Applies when DMWr = 1. Write occurs at the rising edge.
  - SB writes DataWr[7:0]; SH writes DataWr[15:0]; SW writes DataWr[31:0]. Unaddressed bytes are unchanged.
  - Faulting store: suppressed, no bytes written.
- Simultaneous DMWr = 1 and DMRd = 1:
  - The store takes priority and counts as a store only.
  - DataRd = 0 and the load is not counted.
- Read-during-write:
  - A same-cycle load of a location being stored returns the old contents; the new value is visible from the next cycle.
- Fault register (first-fault capture):
  - On the first faulting access (misaligned or illegal, either direction) at a clock edge while Fault = 0: Fault <= 1, FaultCause <= cause, FaultAddr <= Address.
  - Later faults change nothing; the register is cleared only by rst.
  - If an access is both illegal and misaligned, cause = illegal (1).
- Counters:
  - LoadCount increments on each accepted (non-faulting) load cycle. StoreCount increments on each accepted store.
  - Both saturate at 16'hFFFF (no wrap).
  - Faulting accesses do not count.
- Idle:
  - With DMWr = 0 and DMRd = 0, no state changes.

Test Plan:
- Reset, then LW at 0x10 -> DataRd = 0x00000000; Fault = 0; both counters = 0.
- SW 0xDEADBEEF @0x20, then LB @0x20, LBU @0x23, LH @0x22, LHU @0x22 -> 0xFFFFFFEF, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD; StoreCount = 1, LoadCount = 4.
- SB 0x55 @0x21 over the word above, then LW @0x20 -> 0xDEAD55EF (only byte 1 changed).
- SW @0x22 (misaligned) then SH @0x31 -> no memory change; Fault = 1, FaultCause = 0, FaultAddr = 0x00000022 (first fault held); StoreCount unchanged.
- After reset, LW with DMCtrl = 111 @0x40 -> DataRd = 0; Fault = 1, FaultCause = 1. Then SW @0x100 with DEPTH = 256 -> wraps and writes index 0; LW @0x0 returns the stored value.
- Assert rst asynchronously mid-cycle during SW 0x12345678 @0x8 -> no write occurs; memory and all outputs = 0. Separately, 65536 accepted loads -> LoadCount holds 0xFFFF.
